median_window_ctrl: RTL and testbench

//  Streams a raster-order frame through two line buffers into a 3x3 sliding window, drives the window
//  to the 9-input registered median sorter, and emits the median pixel stream with a valid strobe.

---
 rtl/median_pkg.sv | 16 +
 rtl/median_line_buffer.sv | 31 +++
 rtl/median_window_ctrl.sv | 164 ++++++++++++++++
 tb/tb_median_window_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window controller.
package median_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Registered latency of the external 9-input median sorter.
  localparam int unsigned SortLat = 2;
  localparam int unsigned WinSize = 9;

endpackage

// File: rtl/median_line_buffer.sv
// Two cascaded IMG_W-deep delay lines; tap1 is the pixel one row back, tap2 two rows back.
module median_line_buffer #(
  parameter int unsigned n     = 8,
  parameter int unsigned IMG_W = 640
) (
  input  logic         clk,
  input  logic         en,
  input  logic [n-1:0] din,
  output logic [n-1:0] tap1,
  output logic [n-1:0] tap2
);

  logic [n-1:0] line1_q [IMG_W];
  logic [n-1:0] line2_q [IMG_W];

  // Pure data storage; stale contents never reach the output because issue is gated by row/col.
  always_ff @(posedge clk) begin
    if (en) begin
      line1_q[0] <= din;
      line2_q[0] <= line1_q[IMG_W-1];
      for (int unsigned i = 1; i < IMG_W; i++) begin
        line1_q[i] <= line1_q[i-1];
        line2_q[i] <= line2_q[i-1];
      end
    end
  end

  assign tap1 = line1_q[IMG_W-1];
  assign tap2 = line2_q[IMG_W-1];

endmodule

// File: rtl/median_window_ctrl.sv
// Raster stream -> 3x3 window -> external median sorter -> median stream with valid strobe.
// Define MEDIAN_CNT_EN to add a saturating per-frame median counter output (med_count).
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] pix_data,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [n-1:0] win1,
  output logic [n-1:0] win2,
  output logic [n-1:0] win3,
  output logic [n-1:0] win4,
  output logic [n-1:0] win5,
  output logic [n-1:0] win6,
  output logic [n-1:0] win7,
  output logic [n-1:0] win8,
  output logic [n-1:0] win9,
  input  logic [n-1:0] sort_med,
  output logic [n-1:0] med_data,
  output logic         med_valid,
  output logic         frame_done
`ifdef MEDIAN_CNT_EN
  ,
  output logic [15:0]  med_count
`endif
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  state_e state_q, state_d;

  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic [n-1:0]    win_q [WinSize];
  logic            v0_q, v1_q, v2_q;
  logic [1:0]      drain_q;
  logic [n-1:0]    tap1, tap2;
  logic            accept, issue, last_pix, col_last, start_ok;

  assign pix_ready = (state_q == StFill) || (state_q == StRun);
  assign accept    = pix_valid & pix_ready;
  assign start_ok  = (state_q == StIdle) & start;
  assign col_last  = (col_q == ColW'(IMG_W - 1));
  assign last_pix  = col_last && (row_q == RowW'(IMG_H - 1));
  // Only windows whose three columns all lie on the current row pass; col<2 would mix rows.
  assign issue     = accept && (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFill;
      StFill:  if (accept && (row_q == RowW'(2)) && (col_q == '0)) state_d = StRun;
      StRun:   if (accept && last_pix) state_d = StDrain;
      StDrain: if (drain_q == 2'(SortLat)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain covers the window register plus the sorter stages after the final accept.
  always_ff @(posedge clk) begin
    if (reset || (state_q != StDrain)) begin
      drain_q <= '0;
    end else begin
      drain_q <= drain_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + RowW'(1);
      end else begin
        col_q <= col_q + ColW'(1);
      end
    end
  end

  median_line_buffer #(
    .n    (n),
    .IMG_W(IMG_W)
  ) u_line_buffer (
    .clk (clk),
    .en  (accept),
    .din (pix_data),
    .tap1(tap1),
    .tap2(tap2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WinSize; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= tap2;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= tap1;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= pix_data;
    end
  end

  // v0 tracks the window register, v1/v2 track the two sorter stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v0_q <= issue;
      v1_q <= v0_q;
      v2_q <= v1_q;
    end
  end

  assign win1       = win_q[0];
  assign win2       = win_q[1];
  assign win3       = win_q[2];
  assign win4       = win_q[3];
  assign win5       = win_q[4];
  assign win6       = win_q[5];
  assign win7       = win_q[6];
  assign win8       = win_q[7];
  assign win9       = win_q[8];
  assign med_valid  = v2_q;
  assign med_data   = v2_q ? sort_med : '0;
  assign frame_done = (state_q == StDone);

`ifdef MEDIAN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      med_count <= '0;
    end else if (v2_q && (med_count != 16'hFFFF)) begin
      med_count <= med_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl on a 5x4 frame with a behavioural 2-stage median sorter.
module tb_median_window_ctrl;

  localparam int unsigned N = 8;
  localparam int unsigned W = 5;
  localparam int unsigned H = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] pix_data = '0;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [N-1:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
  logic [N-1:0] sort_med = '0;
  logic [N-1:0] s1 = '0;
  logic [N-1:0] med_data;
  logic         med_valid;
  logic         frame_done;
`ifdef MEDIAN_CNT_EN
  logic [15:0]  med_count;
`endif

  always #5 clk = ~clk;

  median_window_ctrl #(
    .n    (N),
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win1      (win1),
    .win2      (win2),
    .win3      (win3),
    .win4      (win4),
    .win5      (win5),
    .win6      (win6),
    .win7      (win7),
    .win8      (win8),
    .win9      (win9),
    .sort_med  (sort_med),
    .med_data  (med_data),
    .med_valid (med_valid),
    .frame_done(frame_done)
`ifdef MEDIAN_CNT_EN
    ,
    .med_count (med_count)
`endif
  );

  function automatic logic [N-1:0] med9(input logic [71:0] v);
    logic [N-1:0] t [9];
    logic [N-1:0] x;
    for (int i = 0; i < 9; i++) t[i] = v[i*8 +: 8];
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (t[j] > t[j+1]) begin
          x = t[j];
          t[j] = t[j+1];
          t[j+1] = x;
        end
      end
    end
    return t[4];
  endfunction

  always @(posedge clk) begin
    s1       <= med9({win1, win2, win3, win4, win5, win6, win7, win8, win9});
    sort_med <= s1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int meds[$];
  int first_cyc, last_cyc, done_cyc, done_cnt, acc12;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (med_valid) begin
      meds.push_back(int'(med_data));
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    meds.delete();
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
    done_cnt  = 0;
  endtask

  function automatic int pix_val(input int mode, input int i);
    if (mode == 0) return i;
    return (i == 6) ? 255 : 10;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input int d, input int gap, input bit st, output int acc);
    int n_wait = 0;
    pix_data  = N'(d);
    pix_valid = 1'b1;
    start     = st;
    while (!pix_ready && n_wait < 20) begin
      @(posedge clk); #1;
      n_wait++;
    end
    if (!pix_ready) check_val("ready_timeout", 0, 1);
    @(posedge clk); #1;
    acc       = cyc;
    pix_valid = 1'b0;
    start     = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input int mode, input int gap, input int start_at);
    int acc;
    int t = 0;
    pulse_start();
    for (int i = 0; i < int'(W * H); i++) begin
      send_pix(pix_val(mode, i), gap, (i == start_at), acc);
      if (i == 12) acc12 = acc;
    end
    while (done_cnt == 0 && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == 0) check_val("done_timeout", done_cnt, 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_meds(input string tag, input int exp [6]);
    check_val({tag, "_count"}, meds.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("%s_med%0d", tag, i), (i < meds.size()) ? meds[i] : -1, exp[i]);
    end
    check_val({tag, "_done_cnt"}, done_cnt, 1);
    check_val({tag, "_done_after_last"}, done_cyc - last_cyc, 1);
  endtask

  // Abort a frame with a synchronous reset right after accepting np pixels.
  task automatic abort_frame(input int np);
    int acc;
    clear_mon();
    pulse_start();
    for (int i = 0; i < np; i++) send_pix(i, 0, 1'b0, acc);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_val($sformatf("abort%0d_stale_valid", np), meds.size(), 0);
    check_val($sformatf("abort%0d_done", np), done_cnt, 0);
    check_val($sformatf("abort%0d_idle_ready", np), int'(pix_ready), 0);
  endtask

  int exp_ramp [6] = '{6, 7, 8, 11, 12, 13};
  int exp_flat [6] = '{10, 10, 10, 10, 10, 10};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_mon();
    acc12 = -1;
    repeat (2) begin
      @(posedge clk);
    end
    #1;
    check_val("rst_pix_ready", int'(pix_ready), 0);
    check_val("rst_med_valid", int'(med_valid), 0);
    check_val("rst_frame_done", int'(frame_done), 0);
    check_val("rst_win1", int'(win1), 0);
    check_val("rst_win5", int'(win5), 0);
    check_val("rst_win9", int'(win9), 0);
    check_val("rst_med_data", int'(med_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    clear_mon();
    run_frame(0, 0, -1);
    check_meds("ramp", exp_ramp);
    // Accept at edge k, med_valid visible after edge k+2.
    check_val("ramp_latency", first_cyc - acc12, 2);

    clear_mon();
    run_frame(1, 0, -1);
    check_meds("flat", exp_flat);

    clear_mon();
    run_frame(0, 1, -1);
    check_meds("gap", exp_ramp);

    abort_frame(9);
    abort_frame(14);
    clear_mon();
    run_frame(0, 0, -1);
    check_meds("post_abort", exp_ramp);

    clear_mon();
    run_frame(0, 0, 15);
    check_meds("run_start", exp_ramp);
    check_val("run_start_idle", int'(pix_ready), 0);
`ifdef MEDIAN_CNT_EN
    check_val("med_count", int'(med_count), 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
